mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback-select stage of the RISC-V core. It captures MEM-stage results each cycle and extracts and extends load data. It drives the architectural writeback port to the register file and the forward_mem_wb value consumed by the forwarding unit. It also counts retired instructions for performance monitoring.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width
CNT_W, 32, retire counter width

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
stall  in  1  hold stage contents
flush  in  1  replace captured entry with bubble
mem_valid  in  1  MEM entry holds a real instruction
mem_rd  in  REG_ADDR_W  destination register
mem_reg_write  in  1  instruction writes rd
mem_result_sel  in  2  00=ALU, 01=LOAD, 10=PC+4, 11=reserved
mem_funct3  in  3  load size/sign (RV32I encoding)
mem_alu_result  in  XLEN  ALU result / load address
mem_pc_plus4  in  XLEN  link value
mem_load_data  in  XLEN  raw aligned word read from data memory
wb_valid  out  1  WB entry valid
wb_rd  out  REG_ADDR_W  writeback register
wb_reg_write  out  1  register file write enable
wb_write_data  out  XLEN  writeback data
forward_mem_wb  out  XLEN  forwarding value, identical to wb_write_data
wb_illegal  out  1  reserved result_sel or illegal load funct3 captured
wb_retired_count  out  CNT_W  count of retired valid instructions

Behaviour:
- Reset (rst_n low at a rising edge): every output register is 0. This covers wb_valid, wb_rd, wb_reg_write, wb_write_data, wb_illegal and wb_retired_count. forward_mem_wb therefore also reads 0.
- All outputs are registered. Latency is 1 cycle from MEM inputs to WB outputs. Writeback data is computed combinationally before the register.
- Priority at each edge: reset, then flush, then stall, then normal capture.
- Flush: loads a bubble. wb_valid, wb_reg_write and wb_illegal are 0, wb_rd is 0, and data is 0. The counter does not increment.
- Stall without flush: all registers hold, including the counter.
- Normal capture: all fields load from the MEM inputs.
- wb_reg_write = mem_valid & mem_reg_write & (mem_rd != 0). A write to x0 never asserts wb_reg_write. The data value is still captured.
- Load extraction uses off = mem_alu_result[1:0]:
  - LB (000): byte off, sign-extended.
  - LBU (100): byte off, zero-extended.
  - LH (001): halfword off[1], sign-extended.
  - LHU (101): halfword off[1], zero-extended; off[0] is ignored.
  - LW (010): full word; off is ignored.
  - funct3 011/110/111 with LOAD selected: data is 0, wb_illegal=1, wb_reg_write=0.
- result_sel 00 gives mem_alu_result and 10 gives mem_pc_plus4. result_sel 11 gives data 0, wb_illegal=1 and wb_reg_write=0.
- wb_illegal is only set when mem_valid=1.
- Counter: on a normal capture with mem_valid=1, wb_retired_count increments by 1, including when wb_illegal is set. It wraps from all-ones to 0.
- Invalid entries (mem_valid=0) still capture data, but wb_valid=0 and wb_reg_write=0.
- Simultaneous stall and flush: flush wins and a bubble is inserted.
- Reset asserted mid-stall clears everything on the next edge. The first capture after reset deasserts happens on the following edge.

Test Plan:
- Reset then idle -> all outputs 0. Pulse rst_n low while the counter is at 5 -> next edge: count 0, wb_valid 0.
- ALU op: valid, rd=3, sel=00, alu=0x1234_5678 -> next cycle wb_reg_write=1, wb_rd=3, wb_write_data=forward_mem_wb=0x1234_5678, count+1.
- Loads on word 0x80FF_7F01:
  - LB off=0 -> 0x0000_0001.
  - LB off=2 -> 0xFFFF_FFFF.
  - LBU off=3 -> 0x0000_0080.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
  - LW -> 0x80FF_7F01.
- rd=0 with reg_write=1, alu=0xDEAD_BEEF -> wb_reg_write=0, wb_write_data=0xDEAD_BEEF, wb_valid=1.
- Stall 3 cycles with changing inputs -> outputs and count frozen. Stall plus flush on the same edge -> bubble, count unchanged.
- LOAD with funct3=011 -> wb_illegal=1, data 0, wb_reg_write=0. With the counter preset to all-ones (forced), one retire -> count 0.

Source files
------------

// File: rtl/mem_wb_if.sv
// MEM/WB stage port bundle: stage controls and MEM-side inputs, plus the
// registered WB-side outputs that feed the register file and forwarding unit.
interface mem_wb_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  stall;
  logic                  flush;
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic [1:0]            mem_result_sel;
  logic [2:0]            mem_funct3;
  logic [XLEN-1:0]       mem_alu_result;
  logic [XLEN-1:0]       mem_pc_plus4;
  logic [XLEN-1:0]       mem_load_data;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_reg_write;
  logic [XLEN-1:0]       wb_write_data;
  logic [XLEN-1:0]       forward_mem_wb;
  logic                  wb_illegal;
  logic [CNT_W-1:0]      wb_retired_count;

  modport master (
    output stall, flush, mem_valid, mem_rd, mem_reg_write, mem_result_sel,
           mem_funct3, mem_alu_result, mem_pc_plus4, mem_load_data,
    input  wb_valid, wb_rd, wb_reg_write, wb_write_data, forward_mem_wb,
           wb_illegal, wb_retired_count
  );

  modport slave (
    input  stall, flush, mem_valid, mem_rd, mem_reg_write, mem_result_sel,
           mem_funct3, mem_alu_result, mem_pc_plus4, mem_load_data,
    output wb_valid, wb_rd, wb_reg_write, wb_write_data, forward_mem_wb,
           wb_illegal, wb_retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects and extends writeback data, registers it
// for the register file and forwarding unit, and counts retired instructions.
module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_wb_if.slave  bus
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_RSVD = 2'b11
  } result_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  logic [7:0]      byte_val;
  logic [15:0]     half_val;
  logic [XLEN-1:0] load_val;
  logic            load_bad;
  logic [XLEN-1:0] wr_data;
  logic            sel_bad;
  logic            next_reg_write;
  logic            next_illegal;

  // NOTE: every signal assigned in always_comb gets a default at the top so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    byte_val = 8'(bus.mem_load_data >> {bus.mem_alu_result[1:0], 3'b000});
    half_val = 16'(bus.mem_load_data >> {bus.mem_alu_result[1], 4'b0000});
    load_val = '0;
    load_bad = 1'b0;
    wr_data  = '0;
    sel_bad  = 1'b0;

    case (load_f3_e'(bus.mem_funct3))
      F3_LB:   load_val = {{(XLEN-8){byte_val[7]}}, byte_val};
      F3_LBU:  load_val = {{(XLEN-8){1'b0}}, byte_val};
      F3_LH:   load_val = {{(XLEN-16){half_val[15]}}, half_val};
      F3_LHU:  load_val = {{(XLEN-16){1'b0}}, half_val};
      F3_LW:   load_val = bus.mem_load_data;
      default: load_bad = 1'b1;
    endcase

    case (result_sel_e'(bus.mem_result_sel))
      SEL_ALU:  wr_data = bus.mem_alu_result;
      SEL_LOAD: begin
        wr_data = load_val;
        sel_bad = load_bad;
      end
      SEL_PC4:  wr_data = bus.mem_pc_plus4;
      default:  sel_bad = 1'b1;
    endcase

    // Illegal entries never write the register file; x0 is never written.
    next_illegal   = bus.mem_valid & sel_bad;
    next_reg_write = bus.mem_valid & bus.mem_reg_write & ~sel_bad &
                     (bus.mem_rd != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.wb_valid         <= 1'b0;
      bus.wb_rd            <= '0;
      bus.wb_reg_write     <= 1'b0;
      bus.wb_write_data    <= '0;
      bus.wb_illegal       <= 1'b0;
      bus.wb_retired_count <= '0;
    end else if (bus.flush) begin
      bus.wb_valid      <= 1'b0;
      bus.wb_rd         <= '0;
      bus.wb_reg_write  <= 1'b0;
      bus.wb_write_data <= '0;
      bus.wb_illegal    <= 1'b0;
    end else if (!bus.stall) begin
      bus.wb_valid      <= bus.mem_valid;
      bus.wb_rd         <= bus.mem_rd;
      bus.wb_reg_write  <= next_reg_write;
      bus.wb_write_data <= wr_data;
      bus.wb_illegal    <= next_illegal;
      if (bus.mem_valid)
        bus.wb_retired_count <= bus.wb_retired_count + CNT_W'(1);
    end
  end

  assign bus.forward_mem_wb = bus.wb_write_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a behavioural model predicts the WB state
// after every edge; a monitor compares the DUT against each prediction.
module tb_mem_wb_stage;
  localparam int XLEN  = 32;
  localparam int RW    = 5;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic            valid;
    logic [RW-1:0]   rd;
    logic            rw;
    logic [XLEN-1:0] data;
    logic            ill;
    logic [CNT_W-1:0] cnt;
    logic            lit_en;
    logic [XLEN-1:0] lit;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_wb_if #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CNT_W)) bus ();

  mem_wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb_q[$];
  exp_t model;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load extraction from the RV32I rules, in plain arithmetic.
  function automatic logic [31:0] load_ref(input logic [31:0] word, input int off, input int f3);
    int b, h;
    b = (word >> (8 * off)) % 256;
    h = (word >> (16 * (off / 2))) % 65536;
    case (f3)
      0: return (b >= 128) ? 32'(b - 256) : 32'(b);
      4: return 32'(b);
      1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      5: return 32'(h);
      default: return word;
    endcase
  endfunction

  // Drive one cycle of stimulus at the falling edge and predict the WB state.
  task automatic step(input logic r, input logic s, input logic f, input logic v,
                      input logic [RW-1:0] rd, input logic rwr, input logic [1:0] sel,
                      input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                      input logic [31:0] ld, input logic lit_en, input logic [31:0] lit);
    bit bad;
    @(negedge clk);
    rst_n              = r;
    bus.stall          = s;
    bus.flush          = f;
    bus.mem_valid      = v;
    bus.mem_rd         = rd;
    bus.mem_reg_write  = rwr;
    bus.mem_result_sel = sel;
    bus.mem_funct3     = f3;
    bus.mem_alu_result = alu;
    bus.mem_pc_plus4   = pc4;
    bus.mem_load_data  = ld;

    if (!r) begin
      model = '0;
    end else if (f) begin
      model.valid = 1'b0;
      model.rd    = '0;
      model.rw    = 1'b0;
      model.data  = '0;
      model.ill   = 1'b0;
    end else if (!s) begin
      bad = (sel == 2'd3) || (sel == 2'd1 && (f3 == 3 || f3 == 6 || f3 == 7));
      if (bad)              model.data = '0;
      else if (sel == 2'd0) model.data = alu;
      else if (sel == 2'd2) model.data = pc4;
      else                  model.data = load_ref(ld, int'(alu % 4), int'(f3));
      model.valid = v;
      model.rd    = rd;
      model.rw    = v && rwr && (rd != 0) && !bad;
      model.ill   = v && bad;
      if (v) model.cnt = CNT_W'((int'(model.cnt) + 1) % (1 << CNT_W));
    end
    model.lit_en = lit_en;
    model.lit    = lit;
    sb_q.push_back(model);
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 1'b0, 1'b0, '0, 1'b0, 2'd0, 3'd0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic op(input logic [RW-1:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                    input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] lit);
    step(1'b1, 1'b0, 1'b0, 1'b1, rd, 1'b1, sel, f3, alu, 32'h0000_1004, ld, 1'b1, lit);
  endtask

  // Monitor: one prediction is consumed per rising edge once stimulus starts.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("wb_valid",         64'(bus.wb_valid),         64'(e.valid));
        check("wb_rd",            64'(bus.wb_rd),            64'(e.rd));
        check("wb_reg_write",     64'(bus.wb_reg_write),     64'(e.rw));
        check("wb_write_data",    64'(bus.wb_write_data),    64'(e.data));
        check("forward_mem_wb",   64'(bus.forward_mem_wb),   64'(e.data));
        check("wb_illegal",       64'(bus.wb_illegal),       64'(e.ill));
        check("wb_retired_count", 64'(bus.wb_retired_count), 64'(e.cnt));
        if (e.lit_en)
          check("directed_data",  64'(bus.wb_write_data),    64'(e.lit));
      end
    end
  end

  initial begin
    localparam logic [31:0] W = 32'h80FF_7F01;
    model = '0;
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.mem_valid = 1'b0; bus.mem_rd = '0;
    bus.mem_reg_write = 1'b0; bus.mem_result_sel = '0; bus.mem_funct3 = '0;
    bus.mem_alu_result = '0; bus.mem_pc_plus4 = '0; bus.mem_load_data = '0;

    idle(1'b0); idle(1'b0); idle(1'b1); idle(1'b1);

    op(5'd3, 2'd0, 3'd0, 32'h1234_5678, '0, 32'h1234_5678);
    op(5'd4, 2'd1, 3'd0, 32'h0000_0100, W,  32'h0000_0001);
    op(5'd5, 2'd1, 3'd0, 32'h0000_0102, W,  32'hFFFF_FFFF);
    op(5'd6, 2'd1, 3'd4, 32'h0000_0103, W,  32'h0000_0080);
    op(5'd7, 2'd1, 3'd1, 32'h0000_0102, W,  32'hFFFF_80FF);
    op(5'd8, 2'd1, 3'd5, 32'h0000_0100, W,  32'h0000_7F01);
    op(5'd9, 2'd1, 3'd2, 32'h0000_0103, W,  W);
    op(5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, '0, 32'hDEAD_BEEF);
    op(5'd10, 2'd2, 3'd0, 32'h0, '0, 32'h0000_1004);

    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 5'(i + 1), 1'b1, 2'd0, 3'd0, $urandom, $urandom, $urandom, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 2'd0, 3'd0, $urandom, '0, '0, 1'b0, '0);
    op(5'd11, 2'd1, 3'd3, 32'h0000_0100, W, 32'h0);
    op(5'd12, 2'd3, 3'd0, 32'h5555_AAAA, W, 32'h0);

    // Reset asserted mid-stall, then first capture on the edge after release.
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 2'd0, 3'd0, 32'h1111_1111, '0, '0, 1'b0, '0);
    op(5'd13, 2'd0, 3'd0, 32'h2222_2222, '0, 32'h2222_2222);

    // Random traffic long enough to wrap the retire counter before any reset.
    for (int i = 0; i < 700; i++) begin
      logic r, s, f;
      r = !(i > 450 && $urandom_range(0, 127) == 0);
      s = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 9) == 0);
      step(r, s, f, ($urandom_range(0, 9) < 8), 5'($urandom), 1'($urandom),
           2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 1'b0, '0);
    end
    idle(1'b1);

    begin
      int budget = 20;
      while (sb_q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (sb_q.size() != 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
